store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Posted-write buffer between the CPU data port (`write_enable`, `address_to_mem`, `data_to_mem`) and the data memory write port. CPU stores are queued in a small FIFO and drained to memory under a valid/ready handshake, so the core only stalls when the buffer is full. Loads to addresses with pending stores return the youngest buffered data. Sits directly downstream of `top`'s data-memory outputs, in front of the data RAM.

## Interface
- `DEPTH`, 4: entries; power of two, 2..16
- `AW`, 32: address width
- `DW`, 32: data width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `cpu_we`  in  1  store request (CPU `write_enable`)
- `cpu_re`  in  1  load request
- `cpu_addr`  in  AW  byte address (CPU `address_to_mem`); compare uses bits [AW-1:2]
- `cpu_wdata`  in  DW  store data (CPU `data_to_mem`)
- `cpu_rdata`  out  DW  load data returned to CPU
- `cpu_stall`  out  1  CPU must hold its current request
- `mem_rdata`  in  DW  combinational read data from RAM at `cpu_addr`
- `mem_wr_valid`  out  1  head entry valid
- `mem_wr_addr`  out  AW  head entry address
- `mem_wr_data`  out  DW  head entry data
- `mem_wr_ready`  in  1  RAM accepts head entry this cycle
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits with wrap-around, plus occupancy counter 0..DEPTH.
- Push: `cpu_we && count<DEPTH`; writes {cpu_addr, cpu_wdata} at tail. No coalescing; repeated stores to one address occupy separate entries.
- Pop: `mem_wr_valid && mem_wr_ready`; advances head.
- Push and pop in the same cycle: both occur; count unchanged. This holds at count==DEPTH only if no push is attempted, because stall is evaluated first (see below).
- `mem_wr_valid = (count!=0)`; `mem_wr_addr`/`mem_wr_data` show the head entry and are held stable while valid && !ready.
- `cpu_we` has priority over `cpu_re`. When both are 1, the cycle is treated as a store only.
- Forwarding (when configured): on `cpu_re`, compare `cpu_addr[AW-1:2]` against all valid entries. On a hit, `cpu_rdata` = youngest matching entry's data. On a miss, `cpu_rdata = mem_rdata`. An entry popped in the current cycle is still eligible.
- `cpu_stall = cpu_we && count==DEPTH`, regardless of `mem_wr_ready`.
- Storage and data registers are not reset. Only pointers and count are reset.

## Timing
- Reset values: count=0, `mem_wr_valid`=0, `cpu_stall`=0, pointers=0. `mem_wr_addr`/`mem_wr_data`/`cpu_rdata` are don't-care while invalid.
- Reset asserted mid-operation: pending entries are discarded, `mem_wr_valid` falls asynchronously, and no further writes are issued.
- Store accepted at edge N appears on `mem_wr_*` from cycle N+1 at the earliest (1-cycle latency). With ready held high, one entry retires per cycle.
- `cpu_rdata` and `cpu_stall` are combinational from the current inputs and registered state. There is no read latency.
- Full: a store is stalled until count<DEPTH at a clock edge. It is accepted on the first cycle after a pop frees a slot.
- Empty: `mem_wr_valid`=0. A pop is impossible, and `mem_wr_ready` is ignored.

## Configuration
- `STORE_BUF_FWD_EN` defined: forwarding compare logic is present, as described above. Loads never stall.
- Not defined: no compare logic and `cpu_rdata = mem_rdata`. `cpu_stall = (cpu_we && count==DEPTH) || (cpu_re && !cpu_we && count!=0)`, so loads wait until the buffer drains to guarantee memory ordering.

## Test plan
- Reset, then one store A=0x10/D=0xDEADBEEF with ready=1 → count=1 next cycle; `mem_wr_valid`=1 with 0x10/0xDEADBEEF for one cycle; count=0 afterwards.
- ready=0, 5 consecutive stores, DEPTH=4 → first 4 accepted; `cpu_stall`=1 on the 5th. Raise ready for one cycle → head pops, 5th store accepted next edge, count stays 4, FIFO order preserved across pointer wrap.
- Stores 0x20→1 then 0x20→2, ready=0, then load 0x22 (FWD_EN) → `cpu_rdata`=2 with no stall. Load 0x24 → `cpu_rdata=mem_rdata`.
- Same sequence without `STORE_BUF_FWD_EN` → load stalls until count=0 after ready raised; `cpu_rdata=mem_rdata`.
- Simultaneous push and pop at count=2 → count stays 2; next head is the previously second entry.
- Reset pulled low with count=3 mid-stream → `mem_wr_valid`=0 immediately; after release, count=0 and no stale entries emerge.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-write buffer: queues CPU stores in a circular FIFO and drains them to the data RAM under valid/ready.
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    cpu_stall,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    mem_wr_valid,
  output logic [AW-1:0]           mem_wr_addr,
  output logic [DW-1:0]           mem_wr_data,
  input  logic                    mem_wr_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          full;
  logic          push;
  logic          pop;

  assign full         = (count == CW'(DEPTH));
  assign mem_wr_valid = (count != '0);
  assign push         = cpu_we && !full;
  assign pop          = mem_wr_valid && mem_wr_ready;

  // Pointers and occupancy are the only reset state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

  assign mem_wr_addr = addr_q[head];
  assign mem_wr_data = data_q[head];

`ifdef STORE_BUF_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match wins; the head entry stays eligible while popping.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign cpu_rdata = (cpu_re && fwd_hit) ? fwd_data : mem_rdata;
  assign cpu_stall = cpu_we && full;
`else
  // Without forwarding, loads wait for the buffer to drain to keep memory ordering.
  assign cpu_rdata = mem_rdata;
  assign cpu_stall = (cpu_we && full) || (cpu_re && !cpu_we && mem_wr_valid);
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we, cpu_re, mem_wr_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, mem_wr_data;
  logic [AW-1:0] mem_wr_addr;
  logic          cpu_stall, mem_wr_valid;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_rdata(mem_rdata),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .count(count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_stall(input logic we, input logic re);
    if (we) return q.size() == DEPTH;
`ifdef STORE_BUF_FWD_EN
    return 1'b0;
`else
    return re && (q.size() != 0);
`endif
  endfunction

  // Youngest buffered store to the same word, else RAM data.
  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a, input logic [DW-1:0] mrd);
`ifdef STORE_BUF_FWD_EN
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[AW-1:2] == a[AW-1:2]) return q[i].d;
`endif
    return mrd;
  endfunction

  task automatic check_outputs(input logic we, input logic re);
    check_eq("count", 64'(count), 64'(q.size()));
    check_eq("valid", 64'(mem_wr_valid), 64'(q.size() != 0));
    check_eq("stall", 64'(cpu_stall), 64'(exp_stall(we, re)));
    if (q.size() != 0) begin
      check_eq("wr_addr", 64'(mem_wr_addr), 64'(q[0].a));
      check_eq("wr_data", 64'(mem_wr_data), 64'(q[0].d));
    end
    if (re && !we) check_eq("rdata", 64'(cpu_rdata), 64'(exp_rdata(cpu_addr, mem_rdata)));
  endtask

  // Called just after a rising edge: drive, check at the falling edge, update model at the next rising edge.
  task automatic cycle(input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy);
    logic do_push, do_pop;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; mem_wr_ready = rdy;
    mem_rdata = $urandom();
    @(negedge clk);
    check_outputs(we, re);
    do_push = we && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: a, d: d});
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_wr_ready = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    logic [AW-1:0] a;
    idle_inputs();
    reset = 1'b0;
    #1;
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_valid", 64'(mem_wr_valid), 64'(0));
    check_eq("rst_stall", 64'(cpu_stall), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single store with ready high retires after one cycle.
    cycle(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    check_eq("single_cnt", 64'(count), 64'(1));
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);

    // Fill with ready low, stall the fifth, free one slot, then drain across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(32'h100 + 4 * i), 32'(32'hA0 + i), 1'b0);
    check_eq("full_cnt", 64'(count), 64'(DEPTH));
    cycle(1'b1, 1'b0, 32'h110, 32'hA4, 1'b1);
    cycle(1'b1, 1'b0, 32'h110, 32'hA4, 1'b0);
    check_eq("refill_cnt", 64'(count), 64'(DEPTH));
    repeat (6) cycle(1'b0, 1'b0, '0, '0, 1'b1);

    // Forwarding / ordering stall on loads to a word with pending stores.
    cycle(1'b1, 1'b0, 32'h20, 32'h1, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 32'h2, 1'b0);
    cycle(1'b0, 1'b1, 32'h22, '0, 1'b0);
    cycle(1'b0, 1'b1, 32'h24, '0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 32'h22, '0, 1'b1);

    // Simultaneous push and pop at count 2.
    cycle(1'b1, 1'b0, 32'h30, 32'h11, 1'b0);
    cycle(1'b1, 1'b0, 32'h34, 32'h22, 1'b0);
    cycle(1'b1, 1'b0, 32'h38, 32'h33, 1'b1);
    check_eq("pp_cnt", 64'(count), 64'(2));
    check_eq("pp_head", 64'(mem_wr_data), 64'(32'h22));
    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b1);

    // Asynchronous reset with three entries pending.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'(32'h40 + 4 * i), 32'(32'h55 + i), 1'b0);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(mem_wr_valid), 64'(0));
    check_eq("mid_rst_count", 64'(count), 64'(0));
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b1);

    // Randomized traffic over a small address pool to exercise forwarding hits.
    for (int n = 0; n < 3000; n++) begin
      a = 32'({$urandom_range(0, 5), 2'($urandom())});
      a = a | 32'h200;
      cycle(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 40), a,
            $urandom(), 1'($urandom_range(0, 99) < 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
